// File: rtl/seg_fade_pkg.sv
// Shared constants and helpers for the segment afterglow fader.
package seg_fade_pkg;

    localparam int unsigned LVL_W      = 4;
    localparam int unsigned LVL_MAX    = (1 << LVL_W) - 1;
    localparam int unsigned DECAY_STEP = 2;
    localparam int unsigned SEG_DP_IDX = 7;

    // Saturating decrement: never wraps below zero.
    function automatic int unsigned sat_dec(input int unsigned level,
                                            input int unsigned step);
        return (level > step) ? (level - step) : 0;
    endfunction

endpackage

// File: rtl/seg_fade_cell.sv
// One segment lane: brightness level with reload / decay / clear, plus PWM compare.
module seg_fade_cell #(
    parameter int unsigned LVL_W      = seg_fade_pkg::LVL_W,
    parameter int unsigned DECAY_STEP = seg_fade_pkg::DECAY_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_seg,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [LVL_W-1:0] i_pwm,
    output logic             o_raw
);
    import seg_fade_pkg::*;

    localparam logic [LVL_W-1:0] L_MAX = '1;

    logic [LVL_W-1:0] r_lvl;

    // Level update: disable clears, a lit segment reloads (beats decay), tick decays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= '0;
        end else if (!i_en) begin
            r_lvl <= '0;
        end else if (i_seg) begin
            r_lvl <= L_MAX;
        end else if (i_tick) begin
            r_lvl <= LVL_W'(sat_dec(32'(r_lvl), DECAY_STEP));
        end
    end

    // Compare is gated by the enable so dropping fade_en silences the glow
    // in the same cycle, before the cleared level has been registered.
    assign o_raw = i_seg | (i_en & (r_lvl > i_pwm));

endmodule

// File: rtl/seg_afterglow_pwm.sv
// Segment afterglow: lit segments fade out over several decay ticks via per-segment PWM.
module seg_afterglow_pwm #(
    parameter int unsigned LVL_W       = seg_fade_pkg::LVL_W,
    parameter int unsigned DECAY_DIV_W = 16,
    parameter int unsigned DECAY_STEP  = seg_fade_pkg::DECAY_STEP,
    parameter logic [7:0]  FADE_MASK   = 8'h7F,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic       fade_en,
    output logic [7:0] seg_out,
    output logic       decay_tick
);
    import seg_fade_pkg::*;

    localparam logic [7:0] OUT_RST = {8{ACTIVE_LOW}};

    logic [DECAY_DIV_W-1:0] r_presc;
    logic [LVL_W-1:0]       r_pwm;
    logic [7:0]             r_seg;
    logic [7:0]             w_raw;
    logic                   w_tick;

    // Free-running decay prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Shared PWM phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    assign w_tick     = &r_presc;
    assign decay_tick = w_tick;

    for (genvar g = 0; g < 8; g++) begin : g_cell
        seg_fade_cell #(
            .LVL_W      (LVL_W),
            .DECAY_STEP (DECAY_STEP)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_seg  (seg_in[g]),
            .i_en   (fade_en & FADE_MASK[g]),
            .i_tick (w_tick),
            .i_pwm  (r_pwm),
            .o_raw  (w_raw[g])
        );
    end

    // Registered pad drive with optional common-anode inversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= OUT_RST;
        end else begin
            r_seg <= w_raw ^ OUT_RST;
        end
    end

    assign seg_out = r_seg;

endmodule

// File: tb/tb_seg_afterglow_pwm.sv
// Scoreboard bench for seg_afterglow_pwm (DECAY_DIV_W=4, LVL_W=4, DECAY_STEP=2).
module tb_seg_afterglow_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic       fade_en;
    logic [7:0] seg_out;
    logic [7:0] seg_out_al;
    logic       decay_tick;
    logic       decay_tick_al;

    always #5 clk = ~clk;

    seg_afterglow_pwm #(
        .DECAY_DIV_W (4),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .fade_en    (fade_en),
        .seg_out    (seg_out),
        .decay_tick (decay_tick)
    );

    seg_afterglow_pwm #(
        .DECAY_DIV_W (4),
        .ACTIVE_LOW  (1'b1)
    ) dut_al (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .fade_en    (fade_en),
        .seg_out    (seg_out_al),
        .decay_tick (decay_tick_al)
    );

    typedef struct {
        int         due;
        int         kind;   // 0 = seg_out word, 1 = decay_tick, 2 = 16-cycle duty
        logic [7:0] mask;
        logic [7:0] exp;
        int         bitn;
        int         duty;
        string      name;
    } chk_t;

    chk_t        sb[$];
    int          cyc     = 0;
    int          nchecks = 0;
    int          nerrors = 0;
    logic [15:0] hist[8];

    function automatic void exp_seg(input int due, input logic [7:0] m,
                                    input logic [7:0] e, input string nm);
        chk_t c;
        c.due = due; c.kind = 0; c.mask = m; c.exp = e;
        c.bitn = 0; c.duty = 0; c.name = nm;
        sb.push_back(c);
    endfunction

    function automatic void exp_tick(input int due, input logic t, input string nm);
        chk_t c;
        c.due = due; c.kind = 1; c.mask = 8'h00; c.exp = {7'd0, t};
        c.bitn = 0; c.duty = 0; c.name = nm;
        sb.push_back(c);
    endfunction

    function automatic void exp_duty(input int due, input int b, input int d,
                                     input string nm);
        chk_t c;
        c.due = due; c.kind = 2; c.mask = 8'h00; c.exp = 8'h00;
        c.bitn = b; c.duty = d; c.name = nm;
        sb.push_back(c);
    endfunction

    // Monitor: samples 1 time unit after each rising edge and retires due checks.
    initial begin
        for (int b = 0; b < 8; b++) hist[b] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) cyc++;
            for (int b = 0; b < 8; b++) hist[b] = {hist[b][14:0], seg_out[b]};
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].kind)
                        0: begin
                            nchecks++;
                            if ((seg_out & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                                nerrors++;
                                $display("FAIL %s @cyc %0d: seg_out=%02h mask=%02h expected=%02h",
                                         sb[i].name, cyc, seg_out, sb[i].mask, sb[i].exp);
                            end
                            nchecks++;
                            if ((seg_out_al & sb[i].mask) !== (~sb[i].exp & sb[i].mask)) begin
                                nerrors++;
                                $display("FAIL %s_al @cyc %0d: seg_out=%02h mask=%02h expected=%02h",
                                         sb[i].name, cyc, seg_out_al, sb[i].mask, ~sb[i].exp);
                            end
                        end
                        1: begin
                            nchecks++;
                            if (decay_tick !== sb[i].exp[0]) begin
                                nerrors++;
                                $display("FAIL %s @cyc %0d: decay_tick=%b expected=%b",
                                         sb[i].name, cyc, decay_tick, sb[i].exp[0]);
                            end
                        end
                        default: begin
                            nchecks++;
                            if ($countones(hist[sb[i].bitn]) != sb[i].duty) begin
                                nerrors++;
                                $display("FAIL %s @cyc %0d: bit%0d duty=%0d expected=%0d",
                                         sb[i].name, cyc, sb[i].bitn,
                                         $countones(hist[sb[i].bitn]), sb[i].duty);
                            end
                        end
                    endcase
                    sb.delete(i);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL timeout: cyc=%0d required=400", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Stimulus: drives at falling edges; inputs set when cyc==k show on seg_out at k+1.
    initial begin
        rst_n   = 1'b0;
        seg_in  = 8'hFF;
        fade_en = 1'b0;
        exp_seg(0, 8'hFF, 8'h00, "reset_out");
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        seg_in = 8'h00;

        // Reset / prescaler
        exp_seg(1, 8'hFF, 8'h00, "post_reset_out");
        exp_tick(14, 1'b0, "tick_c14");
        exp_tick(15, 1'b1, "tick_first");
        exp_tick(16, 1'b0, "tick_c16");
        exp_tick(31, 1'b1, "tick_second");
        exp_tick(46, 1'b0, "tick_c46");
        exp_tick(47, 1'b1, "tick_third");

        // Pass-through
        wait_cyc(2); seg_in = 8'h23; exp_seg(3, 8'hFF, 8'h23, "pass_23");
        wait_cyc(3); seg_in = 8'h40; exp_seg(4, 8'hFF, 8'h40, "pass_40");
        wait_cyc(4); seg_in = 8'h00; exp_seg(5, 8'hFF, 8'h00, "pass_00");
        exp_seg(6, 8'hFF, 8'h00, "pass_no_residue");

        // Fade profile on bit0
        wait_cyc(40); fade_en = 1'b1; seg_in = 8'h01;
        exp_seg(41, 8'h01, 8'h01, "fade_lit");
        wait_cyc(60); seg_in = 8'h00;
        exp_duty(64,  0, 15, "duty_15");
        exp_duty(80,  0, 13, "duty_13");
        exp_duty(96,  0, 11, "duty_11");
        exp_duty(112, 0, 9,  "duty_9");
        exp_duty(128, 0, 7,  "duty_7");
        exp_duty(144, 0, 5,  "duty_5");
        exp_duty(160, 0, 3,  "duty_3");
        exp_duty(176, 0, 1,  "duty_1");
        exp_duty(192, 0, 0,  "duty_0");
        exp_duty(208, 0, 0,  "duty_stays_0");
        exp_seg(200, 8'h01, 8'h00, "fade_dark");

        // Reload in the decay-tick cycle
        wait_cyc(223); seg_in = 8'h08;
        wait_cyc(224); seg_in = 8'h00;
        exp_duty(240, 3, 15, "reload_wins");
        exp_duty(256, 3, 13, "reload_then_decay");
        wait_cyc(256); seg_in = 8'h08;
        for (int c = 257; c <= 290; c++) exp_seg(c, 8'h08, 8'h08, "bit3_hold");
        wait_cyc(290); seg_in = 8'h00;

        // dp lane never fades
        wait_cyc(300); seg_in = 8'h80;
        exp_seg(301, 8'h80, 8'h80, "dp_on");
        wait_cyc(301); seg_in = 8'h00;
        for (int c = 302; c <= 310; c++) exp_seg(c, 8'h80, 8'h00, "dp_no_glow");

        // Abort a fade at L=9
        wait_cyc(320); seg_in = 8'h01;
        wait_cyc(321); seg_in = 8'h00;
        exp_duty(368, 0, 11, "abort_pre_duty");
        exp_seg(372, 8'h01, 8'h01, "abort_pre_on");
        wait_cyc(372); fade_en = 1'b0;
        for (int c = 373; c <= 380; c++) exp_seg(c, 8'hFF, 8'h00, "abort_dark");
        wait_cyc(380); seg_in = 8'h23; exp_seg(381, 8'hFF, 8'h23, "abort_pass_23");
        wait_cyc(381); seg_in = 8'h00;
        for (int c = 382; c <= 384; c++) exp_seg(c, 8'hFF, 8'h00, "abort_pass_00");
        wait_cyc(385); fade_en = 1'b1;
        for (int c = 386; c <= 395; c++) exp_seg(c, 8'hFF, 8'h00, "reenable_no_stale");

        wait_cyc(400);
        @(negedge clk);
        for (int i = 0; i < sb.size(); i++) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s: unchecked at cyc %0d, required due %0d", sb[i].name, cyc, sb[i].due);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
